// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: lamp driver and protocol checker for the 2-bit
// light codes of roads A and B (00=R, 01=G, 10=Y, 11=illegal).
// Each road has its own sequence tracker; sticky error flags and a
// road-A cycle counter are kept at the top level. All outputs registered.
// Optional build macro: TLM_FAILSAFE_EN -- while any sticky error flag is
// set, both lamp outputs are forced to all-red (100).

// Per-road sequence tracker with yellow dwell counter. Emits single-cycle
// event strobes for the sampled code; the top level makes them sticky.
module traffic_light_tracker #(
  parameter int YMIN_CYC = 1,
  parameter int YCNT_W   = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [1:0] code,
  output logic       code_ev,
  output logic       seq_ev,
  output logic       yshort_ev,
  output logic       done_ev
);
  typedef enum logic [1:0] {T_INIT, T_R, T_G, T_Y} trk_e;

  localparam logic [YCNT_W-1:0] YMIN_W = YCNT_W'(YMIN_CYC);
  localparam logic [YCNT_W-1:0] YMAX   = '1;

  trk_e              state, state_n;
  logic [YCNT_W-1:0] ycnt, ycnt_n;

  // State and yellow dwell registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= T_INIT;
      ycnt  <= '0;
    end else begin
      state <= state_n;
      ycnt  <= ycnt_n;
    end
  end

  // Next state follows the code; classify the move and update yellow dwell
  always_comb begin
    state_n   = T_INIT;
    ycnt_n    = '0;
    code_ev   = 1'b0;
    seq_ev    = 1'b0;
    yshort_ev = 1'b0;
    done_ev   = 1'b0;
    case (code)
      2'b00:   state_n = T_R;
      2'b01:   state_n = T_G;
      2'b10:   state_n = T_Y;
      default: begin
        state_n = T_INIT;
        code_ev = 1'b1;
      end
    endcase
    // T_INIT accepts anything; an illegal code already went to T_INIT above
    if (state != T_INIT && state_n != T_INIT) begin
      if ((state == T_G && state_n == T_R) ||
          (state == T_R && state_n == T_Y) ||
          (state == T_Y && state_n == T_G))
        seq_ev = 1'b1;
      if (state == T_Y && state_n == T_R) begin
        if (ycnt < YMIN_W) yshort_ev = 1'b1;
        else               done_ev   = 1'b1;
      end
    end
    if (state_n == T_Y) begin
      if (state != T_Y)       ycnt_n = YCNT_W'(1);
      else if (ycnt != YMAX)  ycnt_n = ycnt + 1'b1;
      else                    ycnt_n = ycnt;
    end
  end
endmodule

module traffic_light_monitor #(
  parameter int YMIN_CYC = 1,
  parameter int YCNT_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [1:0]       i_light_a,
  input  logic [1:0]       i_light_b,
  input  logic             i_clr,
  output logic [2:0]       o_lamp_a,
  output logic [2:0]       o_lamp_b,
  output logic             o_err_code,
  output logic             o_err_seq,
  output logic             o_err_conflict,
  output logic             o_err_yshort,
  output logic [CNT_W-1:0] o_cycle_cnt
);
  // index 0 = road A, index 1 = road B
  logic [1:0] code_ev, seq_ev, yshort_ev, done_ev;
  logic       conflict_ev;
  logic       err_code_n, err_seq_n, err_conflict_n, err_yshort_n;
  logic [2:0] lamp_a_n, lamp_b_n;
  logic       unused_b_done;

  assign unused_b_done = done_ev[1];

  traffic_light_tracker #(.YMIN_CYC(YMIN_CYC), .YCNT_W(YCNT_W)) u_trk [1:0] (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .code      ({i_light_b, i_light_a}),
    .code_ev   (code_ev),
    .seq_ev    (seq_ev),
    .yshort_ev (yshort_ev),
    .done_ev   (done_ev)
  );

  function automatic logic [2:0] decode(input logic [1:0] c);
    case (c)
      2'b00:   decode = 3'b100;
      2'b01:   decode = 3'b001;
      2'b10:   decode = 3'b010;
      default: decode = 3'b000;
    endcase
  endfunction

  // Sticky flags: clear drops old state, a same-cycle event still sets it
  always_comb begin
    conflict_ev    = (i_light_a != 2'b00) && (i_light_b != 2'b00);
    err_code_n     = (o_err_code     & ~i_clr) | (|code_ev);
    err_seq_n      = (o_err_seq      & ~i_clr) | (|seq_ev);
    err_conflict_n = (o_err_conflict & ~i_clr) | conflict_ev;
    err_yshort_n   = (o_err_yshort   & ~i_clr) | (|yshort_ev);
`ifdef TLM_FAILSAFE_EN
    if (err_code_n | err_seq_n | err_conflict_n | err_yshort_n) begin
      lamp_a_n = 3'b100;
      lamp_b_n = 3'b100;
    end else begin
      lamp_a_n = decode(i_light_a);
      lamp_b_n = decode(i_light_b);
    end
`else
    lamp_a_n = decode(i_light_a);
    lamp_b_n = decode(i_light_b);
`endif
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_lamp_a       <= '0;
      o_lamp_b       <= '0;
      o_err_code     <= 1'b0;
      o_err_seq      <= 1'b0;
      o_err_conflict <= 1'b0;
      o_err_yshort   <= 1'b0;
      o_cycle_cnt    <= '0;
    end else begin
      o_lamp_a       <= lamp_a_n;
      o_lamp_b       <= lamp_b_n;
      o_err_code     <= err_code_n;
      o_err_seq      <= err_seq_n;
      o_err_conflict <= err_conflict_n;
      o_err_yshort   <= err_yshort_n;
      if (done_ev[0]) o_cycle_cnt <= o_cycle_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: two instances (default parameters, and
// YMIN_CYC=3 / CNT_W=2) share one directed stimulus stream; a reference
// model pushes expected outputs to per-instance queues when stimulus is
// driven, and they are popped and compared after the sampling edge.
module tb_traffic_light_monitor;
  localparam int R = 0, G = 1, Y = 2, X = 3, INIT = 4;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b1;
  logic [1:0] light_a = 2'b00, light_b = 2'b00;
  logic       clr = 1'b0;

  logic [2:0]  la0, lb0, la1, lb1;
  logic        ec0, es0, ef0, ey0, ec1, es1, ef1, ey1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int tests = 0, fails = 0;

  always #5 i_clk = ~i_clk;

  traffic_light_monitor #(.YMIN_CYC(1), .YCNT_W(8), .CNT_W(16)) dut0 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_light_a(light_a), .i_light_b(light_b),
    .i_clr(clr), .o_lamp_a(la0), .o_lamp_b(lb0), .o_err_code(ec0),
    .o_err_seq(es0), .o_err_conflict(ef0), .o_err_yshort(ey0), .o_cycle_cnt(cnt0));

  traffic_light_monitor #(.YMIN_CYC(3), .YCNT_W(8), .CNT_W(2)) dut1 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_light_a(light_a), .i_light_b(light_b),
    .i_clr(clr), .o_lamp_a(la1), .o_lamp_b(lb1), .o_err_code(ec1),
    .o_err_seq(es1), .o_err_conflict(ef1), .o_err_yshort(ey1), .o_cycle_cnt(cnt1));

  typedef struct {
    logic [2:0] la, lb;
    logic       ec, es, ef, ey;
    int         cnt;
  } exp_t;

  exp_t q0[$], q1[$];

  // reference model state, per instance
  int   prv[2][2];
  int   yc[2][2];
  logic flg[2][4];
  int   mcnt[2];
  int   ymin[2] = '{1, 3};
  int   cmod[2] = '{65536, 4};

  function automatic logic [2:0] dec(input int c);
    case (c)
      0:       return 3'b100;
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      for (int r = 0; r < 2; r++) begin prv[d][r] = INIT; yc[d][r] = 0; end
      for (int k = 0; k < 4; k++) flg[d][k] = 1'b0;
    end
  endtask

  task automatic model(input int d, input int a, input int b, input bit cl, output exp_t e);
    int   code[2];
    logic ev[4];
    int   p, c;
    code[0] = a; code[1] = b;
    for (int k = 0; k < 4; k++) ev[k] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      c = code[r];
      p = prv[d][r];
      if (c == X) begin
        ev[0] = 1'b1;
        prv[d][r] = INIT;
        yc[d][r] = 0;
      end else begin
        if (p != INIT) begin
          if ((p == G && c == R) || (p == R && c == Y) || (p == Y && c == G)) ev[1] = 1'b1;
          if (p == Y && c == R) begin
            if (yc[d][r] < ymin[d]) ev[3] = 1'b1;
            else if (r == 0) mcnt[d] = (mcnt[d] + 1) % cmod[d];
          end
        end
        if (c == Y) yc[d][r] = (p == Y) ? ((yc[d][r] < 255) ? yc[d][r] + 1 : 255) : 1;
        else        yc[d][r] = 0;
        prv[d][r] = c;
      end
    end
    if (a != R && b != R) ev[2] = 1'b1;
    for (int k = 0; k < 4; k++) flg[d][k] = (flg[d][k] & !cl) | ev[k];
    e.la = dec(a);
    e.lb = dec(b);
`ifdef TLM_FAILSAFE_EN
    if (flg[d][0] | flg[d][1] | flg[d][2] | flg[d][3]) begin
      e.la = 3'b100;
      e.lb = 3'b100;
    end
`endif
    e.ec = flg[d][0]; e.es = flg[d][1]; e.ef = flg[d][2]; e.ey = flg[d][3];
    e.cnt = mcnt[d];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input int d, input exp_t e, input string tag);
    if (d == 0) begin
      chk({tag, " d0 lamp_a"}, {29'b0, la0}, {29'b0, e.la});
      chk({tag, " d0 lamp_b"}, {29'b0, lb0}, {29'b0, e.lb});
      chk({tag, " d0 err_code"}, {31'b0, ec0}, {31'b0, e.ec});
      chk({tag, " d0 err_seq"}, {31'b0, es0}, {31'b0, e.es});
      chk({tag, " d0 err_conflict"}, {31'b0, ef0}, {31'b0, e.ef});
      chk({tag, " d0 err_yshort"}, {31'b0, ey0}, {31'b0, e.ey});
      chk({tag, " d0 cycle_cnt"}, {16'b0, cnt0}, e.cnt);
    end else begin
      chk({tag, " d1 lamp_a"}, {29'b0, la1}, {29'b0, e.la});
      chk({tag, " d1 lamp_b"}, {29'b0, lb1}, {29'b0, e.lb});
      chk({tag, " d1 err_code"}, {31'b0, ec1}, {31'b0, e.ec});
      chk({tag, " d1 err_seq"}, {31'b0, es1}, {31'b0, e.es});
      chk({tag, " d1 err_conflict"}, {31'b0, ef1}, {31'b0, e.ef});
      chk({tag, " d1 err_yshort"}, {31'b0, ey1}, {31'b0, e.ey});
      chk({tag, " d1 cycle_cnt"}, {30'b0, cnt1}, e.cnt);
    end
  endtask

  // Drive one cycle of codes, queue the expectation, compare after the edge
  task automatic step(input string tag, input int a, input int b, input bit cl = 1'b0);
    exp_t e;
    light_a = 2'(a);
    light_b = 2'(b);
    clr = cl;
    model(0, a, b, cl, e); q0.push_back(e);
    model(1, a, b, cl, e); q1.push_back(e);
    @(posedge i_clk);
    #1;
    if (q0.size() == 0 || q1.size() == 0) begin
      fails++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      cmp(0, q0.pop_front(), tag);
      cmp(1, q1.pop_front(), tag);
    end
  endtask

  task automatic chk_zero(input string tag);
    exp_t z;
    z.la = 3'b000; z.lb = 3'b000;
    z.ec = 1'b0; z.es = 1'b0; z.ef = 1'b0; z.ey = 1'b0; z.cnt = 0;
    cmp(0, z, tag);
    cmp(1, z, tag);
  endtask

  task automatic cycle_a(input string tag, input int ylen);
    step(tag, G, R);
    for (int i = 0; i < ylen; i++) step(tag, Y, R);
    step(tag, R, R);
  endtask

  initial begin
    // 1: reset and a basic two-road rotation
    model_reset();
    #1 i_rstn = 1'b0;
    #1 chk_zero("reset_async");
    @(posedge i_clk); #1;
    chk_zero("reset_held");
    @(negedge i_clk) i_rstn = 1'b1;
    step("t1", G, R);
    step("t1", Y, R);
    step("t1", R, G);
    step("t1", R, Y);
    step("t1", G, R);
    chk("t1 d0 cycle_cnt_is_1", {16'b0, cnt0}, 32'd1);

    // 2: G->R on road A, flag holds over legal traffic, then clear
    step("t2_bad", R, R);
    chk("t2 d0 err_seq_set", {31'b0, es0}, 32'd1);
    for (int i = 0; i < 10; i++) step("t2_hold", R, R);
    step("t2_clr", R, R, 1'b1);
    chk("t2 d0 err_seq_cleared", {31'b0, es0}, 32'd0);
    step("t2_after", R, R);

    // 3: conflict, illegal code, resync from T_INIT
    step("t3_conf", G, G);
    step("t3_code", X, R);
    chk("t3 d0 lamp_a_dark", {29'b0, la0}, 32'd0);
    step("t3_resync", R, R);
    step("t3_clr", R, R, 1'b1);

    // 4: short and adequate yellow (YMIN=3 on dut1)
    cycle_a("t4_short", 2);
    chk("t4 d1 yshort_set", {31'b0, ey1}, 32'd1);
    step("t4_clr", R, R, 1'b1);
    cycle_a("t4_long", 3);

    // 5: counter wrap on the narrow instance, clear vs same-cycle conflict
    for (int i = 0; i < 4; i++) cycle_a("t5_wrap", 3);
    step("t5_conf", G, G);
    step("t5_clr_conf", G, G, 1'b1);
    chk("t5 d0 conflict_kept", {31'b0, ef0}, 32'd1);
    step("t5_idle", R, R, 1'b1);
    step("t5_idle", R, R);

    // 6: illegal R->Y, lamps during error, clear, then reset mid-sequence
    step("t6_bad", Y, R);
    step("t6_hold", R, R);
    step("t6_hold", G, R);
    step("t6_clr", G, R, 1'b1);
    step("t6_run", Y, R);
    i_rstn = 1'b0;
    model_reset();
    #1 chk_zero("t6_midreset");
    @(negedge i_clk) i_rstn = 1'b1;
    step("t6_first", Y, R);
    step("t6_next", R, R);

    // 7: mixed random traffic including illegal codes and clears
    for (int i = 0; i < 60; i++)
      step("t7_rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
